// File: rtl/rf_pkg.sv
// ============================================================================
// Module  : rf_pkg
// Brief   : Shared RF bus entry layout and fill FSM encoding (fill + writeback)
// Revision: 1.0
// ============================================================================
`default_nettype none

package rf_pkg;

  localparam int RF_ENTRY_W    = 35;
  localparam int RF_DATA_W     = 16;
  localparam int RF_VAL_LSB    = 0;
  localparam int RF_TAG_LSB    = 16;
  localparam int RF_LOCKED_BIT = 32;
  localparam int RF_RETR_BIT   = 33;
  localparam int RF_VALID_BIT  = 34;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FILL = 2'd3
  } fill_state_t;

  function automatic logic [RF_ENTRY_W-1:0] rf_pack(
    input logic                 valid,
    input logic                 retr,
    input logic                 locked,
    input logic [RF_DATA_W-1:0] tag,
    input logic [RF_DATA_W-1:0] val
  );
    return {valid, retr, locked, tag, val};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin pick of the first pending bit at or after ptr
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NCORES = 4,
  parameter int PW     = (NCORES > 1) ? $clog2(NCORES) : 1
) (
  input  logic [NCORES-1:0] pending,
  input  logic [PW-1:0]     rr_ptr,
  output logic [NCORES-1:0] grant_oh,
  output logic [PW-1:0]     grant_idx,
  output logic              any_pending
);

  logic          w_found;
  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;

  always_comb begin
    grant_oh    = '0;
    grant_idx   = '0;
    any_pending = |pending;
    w_found     = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    // Walk outward from the pointer; the extra sum bit catches the wrap.
    for (int k = 0; k < NCORES; k++) begin
      w_sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NCORES))
        w_sum = w_sum - (PW+1)'(NCORES);
      w_idx = w_sum[PW-1:0];
      if (!w_found && pending[w_idx]) begin
        w_found         = 1'b1;
        grant_oh[w_idx] = 1'b1;
        grant_idx       = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rf_fill.sv
// ============================================================================
// Module  : rf_fill
// Brief   : RF fill engine; one memory read at a time for retrieve-pending
//           entries, round-robin. Option macro: RF_FILL_COALESCE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rf_fill
  import rf_pkg::*;
#(
  parameter int NCORES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NCORES*RF_ENTRY_W-1:0] rf_in,
  output logic [NCORES*RF_ENTRY_W-1:0] rf_out,
  output logic                         mem_rd_req,
  output logic [RF_DATA_W-1:0]         mem_rd_addr,
  input  logic                         mem_rd_gnt,
  input  logic                         mem_rd_valid,
  input  logic [RF_DATA_W-1:0]         mem_rd_data,
  output logic                         busy
);

  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

  fill_state_t          r_state;
  fill_state_t          w_next_state;
  logic [PW-1:0]        r_rr_ptr;
  logic [PW-1:0]        r_sel_idx;
  logic [RF_DATA_W-1:0] r_sel_tag;
  logic [RF_DATA_W-1:0] r_fill_data;
  logic                 r_rd_req;
  logic [RF_DATA_W-1:0] r_rd_addr;

  logic [NCORES-1:0]    w_pending;
  logic [NCORES-1:0]    w_grant_oh;
  logic [PW-1:0]        w_grant_idx;
  logic                 w_any_pending;
  logic [RF_DATA_W-1:0] w_grant_tag;
  logic [PW-1:0]        w_ptr_next;
  logic                 w_fill;

  rr_arbiter #(
    .NCORES (NCORES),
    .PW     (PW)
  ) u_arb (
    .pending     (w_pending),
    .rr_ptr      (r_rr_ptr),
    .grant_oh    (w_grant_oh),
    .grant_idx   (w_grant_idx),
    .any_pending (w_any_pending)
  );

  always_comb begin
    w_grant_tag = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (w_grant_oh[i])
        w_grant_tag = w_grant_tag | rf_in[i*RF_ENTRY_W + RF_TAG_LSB +: RF_DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_any_pending) w_next_state = ST_REQ;
      ST_REQ:  if (mem_rd_gnt)    w_next_state = ST_WAIT;
      ST_WAIT: if (mem_rd_valid)  w_next_state = ST_FILL;
      ST_FILL: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_ptr_next = (r_sel_idx == PW'(NCORES - 1)) ? '0 : r_sel_idx + 1'b1;

  // Selection is captured once on IDLE exit and held until FILL completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_sel_idx   <= '0;
      r_sel_tag   <= '0;
      r_fill_data <= '0;
      r_rd_req    <= 1'b0;
      r_rd_addr   <= '0;
    end else begin
      if (r_state == ST_IDLE && w_any_pending) begin
        r_sel_idx <= w_grant_idx;
        r_sel_tag <= w_grant_tag;
        r_rd_req  <= 1'b1;
        r_rd_addr <= w_grant_tag;
      end
      if (r_state == ST_REQ && mem_rd_gnt)
        r_rd_req <= 1'b0;
      if (r_state == ST_WAIT && mem_rd_valid)
        r_fill_data <= mem_rd_data;
      if (r_state == ST_FILL)
        r_rr_ptr <= w_ptr_next;
    end
  end

  assign w_fill      = (r_state == ST_FILL);
  assign mem_rd_req  = r_rd_req;
  assign mem_rd_addr = r_rd_addr;
  assign busy        = (r_state != ST_IDLE);

  for (genvar i = 0; i < NCORES; i++) begin : g_entry
    logic [RF_ENTRY_W-1:0] w_ent;
    logic [RF_DATA_W-1:0]  w_tag;
    logic                  w_tag_hit;
    logic                  w_hit;

    assign w_ent        = rf_in[i*RF_ENTRY_W +: RF_ENTRY_W];
    assign w_tag        = w_ent[RF_TAG_LSB +: RF_DATA_W];
    assign w_pending[i] = w_ent[RF_RETR_BIT] & ~w_ent[RF_VALID_BIT];
    // A retagged or no-longer-retrieving entry must not take stale data.
    assign w_tag_hit    = w_ent[RF_RETR_BIT] && (w_tag == r_sel_tag);

`ifdef RF_FILL_COALESCE_EN
    assign w_hit = w_fill && w_tag_hit &&
                   ((r_sel_idx == PW'(i)) || !w_ent[RF_VALID_BIT]);
`else
    assign w_hit = w_fill && w_tag_hit && (r_sel_idx == PW'(i));
`endif

    assign rf_out[i*RF_ENTRY_W +: RF_ENTRY_W] =
      w_hit ? rf_pack(1'b1, 1'b0, w_ent[RF_LOCKED_BIT], w_tag, r_fill_data) : w_ent;
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_fill.sv
// ============================================================================
// Module  : tb_rf_fill
// Brief   : Directed self-checking bench for rf_fill (NCORES=4)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rf_fill;

  logic         clk;
  logic         rst;
  logic [139:0] rf_in;
  logic [139:0] rf_out;
  logic         mem_rd_req;
  logic [15:0]  mem_rd_addr;
  logic         mem_rd_gnt;
  logic         mem_rd_valid;
  logic [15:0]  mem_rd_data;
  logic         busy;

  logic [34:0]  e [4];
  logic [34:0]  x [4];
  int           n_cmp;
  int           n_err;

  assign rf_in = {e[3], e[2], e[1], e[0]};

  rf_fill #(.NCORES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rf_in        (rf_in),
    .rf_out       (rf_out),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_gnt   (mem_rd_gnt),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [34:0] ent(input logic v, input logic r, input logic l,
                                     input logic [15:0] t, input logic [15:0] d);
    return {v, r, l, t, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [139:0] obs, input logic [139:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Bounded wait for the request, then check its address.
  task automatic wait_req(input logic [15:0] exp_addr);
    for (int k = 0; k < 8 && mem_rd_req !== 1'b1; k++) tick();
    chk("req_rise", mem_rd_req, 140'(1));
    chk("req_addr", mem_rd_addr, 140'(exp_addr));
    chk("req_busy", busy, 140'(1));
  endtask

  // Grant in REQ, then one-cycle data in WAIT; returns in the FILL cycle.
  task automatic grant_data(input logic [15:0] d);
    mem_rd_gnt = 1'b1;
    tick();
    mem_rd_gnt = 1'b0;
    chk("req_drop", mem_rd_req, 140'(0));
    mem_rd_valid = 1'b1;
    mem_rd_data  = d;
    tick();
    mem_rd_valid = 1'b0;
    mem_rd_data  = 16'h0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    mem_rd_gnt = 1'b1;
    mem_rd_valid = 1'b0;
    mem_rd_data = 16'h0;
    e[0] = ent(1'b1, 1'b0, 1'b0, 16'hA000, 16'h0001);
    e[1] = ent(1'b0, 1'b0, 1'b1, 16'h0B00, 16'h0000);
    e[2] = ent(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    e[3] = ent(1'b1, 1'b1, 1'b1, 16'h0C00, 16'h5555);
    tick();
    tick();

    // Reset state
    chk("rst_req", mem_rd_req, 140'(0));
    chk("rst_addr", mem_rd_addr, 140'(0));
    chk("rst_busy", busy, 140'(0));
    chk("rst_pass", rf_out, rf_in);

    // Single fill of entry 2 with immediate grant
    rst = 1'b0;
    tick();
    chk("t1_req", mem_rd_req, 140'(1));
    chk("t1_addr", mem_rd_addr, 140'h0010);
    tick();
    chk("t1_req_drop", mem_rd_req, 140'(0));
    chk("t1_busy_wait", busy, 140'(1));
    mem_rd_gnt = 1'b0;
    mem_rd_valid = 1'b1;
    mem_rd_data = 16'hBEEF;
    tick();
    mem_rd_valid = 1'b0;
    x = e;
    x[2] = ent(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF);
    chk("t1_fill", rf_out, {x[3], x[2], x[1], x[0]});
    tick();
    chk("t1_after", rf_out, rf_in);
    chk("t1_idle", busy, 140'(0));
    e[2] = x[2];
    tick();
    chk("t1_quiet_req", mem_rd_req, 140'(0));
    chk("t1_quiet_busy", busy, 140'(0));

    // Round-robin over 0,1,3 from rr_ptr=0
    rst = 1'b1;
    tick();
    e[0] = ent(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0AAA);
    e[1] = ent(1'b0, 1'b1, 1'b1, 16'h0101, 16'h0000);
    e[3] = ent(1'b0, 1'b1, 1'b0, 16'h0103, 16'h0000);
    rst = 1'b0;
    wait_req(16'h0100);
    grant_data(16'h0A0A);
    x = e;
    x[0] = ent(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0A0A);
    chk("rr_fill0", rf_out, {x[3], x[2], x[1], x[0]});
    tick();
    e[0] = x[0];
    wait_req(16'h0101);
    grant_data(16'h0B0B);
    x = e;
    x[1] = ent(1'b1, 1'b0, 1'b1, 16'h0101, 16'h0B0B);
    chk("rr_fill1", rf_out, {x[3], x[2], x[1], x[0]});
    tick();
    e[1] = x[1];
    wait_req(16'h0103);
    e[0] = ent(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0A0A);
    grant_data(16'h0C0C);
    x = e;
    x[3] = ent(1'b1, 1'b0, 1'b0, 16'h0103, 16'h0C0C);
    chk("rr_fill3", rf_out, {x[3], x[2], x[1], x[0]});
    tick();
    e[3] = x[3];

    // Re-pended entry 0 next; grant withheld 5 cycles with a stray data pulse
    wait_req(16'h0100);
    for (int k = 0; k < 5; k++) begin
      mem_rd_valid = (k == 2);
      mem_rd_data  = (k == 2) ? 16'hDEAD : 16'h0000;
      tick();
      chk("hold_req", mem_rd_req, 140'(1));
      chk("hold_addr", mem_rd_addr, 140'h0100);
    end
    mem_rd_valid = 1'b0;
    mem_rd_data = 16'h0;
    chk("hold_pass", rf_out, rf_in);
    grant_data(16'h0D0D);
    x = e;
    x[0] = ent(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0D0D);
    chk("hold_fill", rf_out, {x[3], x[2], x[1], x[0]});
    tick();
    e[0] = x[0];

    // Retag during WAIT: fill dropped, pointer still advances past entry 1
    e[1] = ent(1'b0, 1'b1, 1'b1, 16'h0020, 16'h0B0B);
    wait_req(16'h0020);
    mem_rd_gnt = 1'b1;
    tick();
    mem_rd_gnt = 1'b0;
    e[1] = ent(1'b0, 1'b1, 1'b1, 16'h0030, 16'h0B0B);
    e[3] = ent(1'b0, 1'b1, 1'b0, 16'h0300, 16'h0C0C);
    mem_rd_valid = 1'b1;
    mem_rd_data = 16'h7777;
    tick();
    mem_rd_valid = 1'b0;
    chk("retag_busy", busy, 140'(1));
    chk("retag_drop", rf_out, rf_in);
    tick();
    wait_req(16'h0300);
    grant_data(16'h3333);
    x = e;
    x[3] = ent(1'b1, 1'b0, 1'b0, 16'h0300, 16'h3333);
    chk("retag_fill3", rf_out, {x[3], x[2], x[1], x[0]});
    tick();
    e[3] = x[3];
    wait_req(16'h0030);
    grant_data(16'h3030);
    x = e;
    x[1] = ent(1'b1, 1'b0, 1'b1, 16'h0030, 16'h3030);
    chk("retag_fill1", rf_out, {x[3], x[2], x[1], x[0]});
    tick();
    e[1] = x[1];

    // Two entries waiting on the same tag; rr_ptr=2 selects entry 2 first
    e[0] = ent(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0D0D);
    e[2] = ent(1'b0, 1'b1, 1'b0, 16'h0040, 16'hBEEF);
    wait_req(16'h0040);
    grant_data(16'h1234);
    x = e;
    x[2] = ent(1'b1, 1'b0, 1'b0, 16'h0040, 16'h1234);
`ifdef RF_FILL_COALESCE_EN
    x[0] = ent(1'b1, 1'b0, 1'b0, 16'h0040, 16'h1234);
`endif
    chk("same_tag_fill", rf_out, {x[3], x[2], x[1], x[0]});
    tick();
    e = x;
`ifdef RF_FILL_COALESCE_EN
    tick();
    chk("coal_no_req", mem_rd_req, 140'(0));
    chk("coal_idle", busy, 140'(0));
`else
    wait_req(16'h0040);
    grant_data(16'h1234);
    x = e;
    x[0] = ent(1'b1, 1'b0, 1'b0, 16'h0040, 16'h1234);
    chk("same_tag_fill0", rf_out, {x[3], x[2], x[1], x[0]});
    tick();
    e[0] = x[0];
`endif

    // Reset while in WAIT, then a late data pulse
    e[3] = ent(1'b0, 1'b1, 1'b0, 16'h0050, 16'h3333);
    wait_req(16'h0050);
    mem_rd_gnt = 1'b1;
    tick();
    mem_rd_gnt = 1'b0;
    chk("rw_busy_wait", busy, 140'(1));
    rst = 1'b1;
    tick();
    chk("rw_req", mem_rd_req, 140'(0));
    chk("rw_busy", busy, 140'(0));
    chk("rw_pass", rf_out, rf_in);
    rst = 1'b0;
    mem_rd_valid = 1'b1;
    mem_rd_data = 16'h9999;
    #1;
    chk("rw_late_pass", rf_out, rf_in);
    tick();
    mem_rd_valid = 1'b0;
    chk("rw_late_pass2", rf_out, rf_in);
    chk("rw_rereq", mem_rd_req, 140'(1));
    chk("rw_rereq_addr", mem_rd_addr, 140'h0050);
    tick();
    chk("rw_still_req", busy, 140'(1));
    chk("rw_final_pass", rf_out, rf_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
